// File: rtl/fb_pkg.sv
// Shared types and constants for the frame-buffer write path.
package fb_pkg;

  typedef logic [7:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } fb_wr_state_t;

  localparam int     FB_ADDR_W   = 16;
  localparam pixel_t FB_BG_PIXEL = 8'h7E;

endpackage

// File: rtl/fb_raster_counter.sv
// Raster position counter: tracks row/col and the matching linear RAM address,
// flagging the final pixel of the frame.
module fb_raster_counter
  import fb_pkg::*;
#(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int ADDR_W = FB_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  assign last = (row == ROW_LAST) && (col == COL_LAST);

  // Stepping the address by one per pixel keeps it equal to row*IMG_W+col
  // without a multiplier; after the final pixel everything returns to 0.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else if (enable) begin
      if (last) begin
        col  <= '0;
        row  <= '0;
        addr <= '0;
      end else begin
        addr <= addr + 1'b1;
        if (col == COL_LAST) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/frame_buffer_writer.sv
// Streams a raster-ordered pixel frame into the frame-buffer RAM, yielding to the drawer.
// Optional running pixel checksum enabled by defining FB_WRITER_CKSUM_EN.
module frame_buffer_writer
  import fb_pkg::*;
#(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int ADDR_W = FB_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              draw_active,
  input  logic              in_valid,
  input  logic [7:0]        in_pixel,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_wren,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       checksum
);

  if (longint'(IMG_W) * longint'(IMG_H) > (longint'(1) << ADDR_W)) begin : g_size_check
    $error("frame_buffer_writer: IMG_W*IMG_H does not fit in ADDR_W address bits");
  end

  fb_wr_state_t      state;
  logic              accept;
  logic              frame_start;
  logic [ADDR_W-1:0] cnt_addr;
  logic              cnt_last;

  // The drawer owns the RAM whenever draw_active is high, so back-pressure the source then.
  assign in_ready    = (state == LOAD) && !draw_active;
  assign accept      = in_valid && in_ready;
  assign frame_start = (state == IDLE) && start;

  fb_raster_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ADDR_W(ADDR_W)
  ) u_counter (
    .clk   (clk),
    .reset (reset),
    .clear (frame_start),
    .enable(accept),
    .addr  (cnt_addr),
    .last  (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      mem_addr   <= '0;
      mem_data   <= '0;
      mem_wren   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      mem_wren   <= accept;
      frame_done <= 1'b0;
      if (accept) begin
        mem_addr <= cnt_addr;
        mem_data <= in_pixel;
      end
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          if (accept && cnt_last) begin
            state      <= DONE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FB_WRITER_CKSUM_EN
  always_ff @(posedge clk) begin
    if (reset || frame_start) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= checksum + {8'h00, in_pixel};
    end
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Bench for frame_buffer_writer with 4x2, 3x2 and 256x256 instances sharing one stimulus port.
// Checksum expectations track FB_WRITER_CKSUM_EN.
module tb_frame_buffer_writer;
  import fb_pkg::*;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  logic   start = 1'b0;
  logic   draw_active = 1'b0;
  logic   in_valid = 1'b0;
  pixel_t in_pixel = '0;
  int     sel = 0;

  logic        o_ready[3];
  logic        o_wren[3];
  logic        o_busy[3];
  logic        o_done[3];
  logic [15:0] o_addr[3];
  logic [15:0] o_cksum[3];
  logic [7:0]  o_data[3];

  int   checks = 0;
  int   fails = 0;
  logic ready_seen;
  logic ready_exp;

  logic        m_loading = 1'b0;
  logic        m_in_done = 1'b0;
  logic        m_wren = 1'b0;
  logic        m_done = 1'b0;
  logic        m_acc;
  int          m_count = 0;
  logic [15:0] m_addr = '0;
  logic [15:0] m_cksum = '0;
  pixel_t      m_data = '0;

  logic [42:0] mon;
  logic [42:0] exp_mon;
  logic [15:0] m_cksum_exp;
  logic        cur_ready;

`ifdef FB_WRITER_CKSUM_EN
  assign m_cksum_exp = m_cksum;
`else
  assign m_cksum_exp = 16'h0000;
`endif

  assign mon       = {o_wren[sel], o_done[sel], o_busy[sel], o_addr[sel], o_data[sel], o_cksum[sel]};
  assign exp_mon   = {m_wren, m_done, m_loading, m_addr, m_data, m_cksum_exp};
  assign cur_ready = o_ready[sel];

  always #5 clk = ~clk;

  frame_buffer_writer #(.IMG_W(4), .IMG_H(2), .ADDR_W(16)) dut_a (
    .clk(clk), .reset(reset), .start(start && sel == 0), .draw_active(draw_active),
    .in_valid(in_valid && sel == 0), .in_pixel(in_pixel), .in_ready(o_ready[0]),
    .mem_addr(o_addr[0]), .mem_data(o_data[0]), .mem_wren(o_wren[0]),
    .busy(o_busy[0]), .frame_done(o_done[0]), .checksum(o_cksum[0])
  );

  frame_buffer_writer #(.IMG_W(3), .IMG_H(2), .ADDR_W(16)) dut_b (
    .clk(clk), .reset(reset), .start(start && sel == 1), .draw_active(draw_active),
    .in_valid(in_valid && sel == 1), .in_pixel(in_pixel), .in_ready(o_ready[1]),
    .mem_addr(o_addr[1]), .mem_data(o_data[1]), .mem_wren(o_wren[1]),
    .busy(o_busy[1]), .frame_done(o_done[1]), .checksum(o_cksum[1])
  );

  frame_buffer_writer dut_c (
    .clk(clk), .reset(reset), .start(start && sel == 2), .draw_active(draw_active),
    .in_valid(in_valid && sel == 2), .in_pixel(in_pixel), .in_ready(o_ready[2]),
    .mem_addr(o_addr[2]), .mem_data(o_data[2]), .mem_wren(o_wren[2]),
    .busy(o_busy[2]), .frame_done(o_done[2]), .checksum(o_cksum[2])
  );

  function automatic int frame_pixels(input int s);
    return (s == 0) ? 8 : (s == 1) ? 6 : 65536;
  endfunction

  // Reference: a frame is a count of accepted pixels; the write shows up one cycle after acceptance.
  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_loading = 1'b0; m_in_done = 1'b0; m_count = 0;
        m_wren = 1'b0; m_done = 1'b0; m_addr = '0; m_data = '0; m_cksum = '0;
      end else begin
        m_acc  = m_loading && !draw_active && in_valid;
        m_wren = m_acc;
        m_done = 1'b0;
        if (m_acc) begin
          m_addr  = 16'(m_count);
          m_data  = in_pixel;
          m_cksum = m_cksum + 16'(in_pixel);
          m_count = m_count + 1;
          if (m_count == frame_pixels(sel)) begin
            m_loading = 1'b0;
            m_done    = 1'b1;
          end
        end else if (!m_loading && !m_in_done && start) begin
          m_loading = 1'b1;
          m_count   = 0;
          m_cksum   = '0;
        end
        m_in_done = m_done;
      end
    end
  end

  task automatic drive_cycle(input logic st, input logic da, input logic v, input pixel_t px);
    start = st; draw_active = da; in_valid = v; in_pixel = px;
    #1;
    ready_seen = cur_ready;
    ready_exp  = m_loading && !da;
    @(negedge clk);
  endtask

  task automatic select_and_reset(input int s);
    sel = s; reset = 1'b1;
    drive_cycle(1'b0, 1'b0, 1'b0, 8'h00);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    sel = 0; reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive_cycle(1'b1, 1'b0, 1'b1, 8'hFF);
      checks++;
      if (mon !== 43'h0) begin fails++; $display("[TB] FAIL reset_outputs cyc%0d: got %h, want 0", c, mon); end
      checks++;
      if (cur_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_ready cyc%0d: got %b, want 0", c, cur_ready); end
    end
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    select_and_reset(0);
    drive_cycle(1'b1, 1'b0, 1'b0, 8'h00);
    checks++;
    if (mon !== exp_mon) begin fails++; $display("[TB] FAIL b2b_start: got %h, want %h", mon, exp_mon); end
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b1, pixel_t'(8'h10 + i));
      checks++;
      if (mon !== exp_mon) begin fails++; $display("[TB] FAIL b2b_model px%0d: got %h, want %h", i, mon, exp_mon); end
      checks++;
      if (ready_seen !== ready_exp) begin fails++; $display("[TB] FAIL b2b_ready px%0d: got %b, want %b", i, ready_seen, ready_exp); end
      checks++;
      if (o_wren[0] !== 1'b1 || o_addr[0] !== 16'(i) || o_data[0] !== pixel_t'(8'h10 + i) ||
          o_done[0] !== (i == 7) || o_busy[0] !== (i != 7)) begin
        fails++;
        $display("[TB] FAIL b2b_write px%0d: got wren=%b addr=%h data=%h done=%b busy=%b, want addr=%h data=%h",
                 i, o_wren[0], o_addr[0], o_data[0], o_done[0], o_busy[0], 16'(i), pixel_t'(8'h10 + i));
      end
    end
    drive_cycle(1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if (o_wren[0] !== 1'b0 || o_done[0] !== 1'b0 || o_busy[0] !== 1'b0 || o_addr[0] !== 16'd7) begin
      fails++;
      $display("[TB] FAIL b2b_after: got wren=%b done=%b busy=%b addr=%h, want 0/0/0/0007",
               o_wren[0], o_done[0], o_busy[0], o_addr[0]);
    end
  endtask

  task automatic test_draw_stall();
    int done_cnt = 0;
    select_and_reset(0);
    for (int f = 0; f < 3; f++) begin
      pixel_t q[$];
      for (int k = 0; k < 8; k++) q.push_back(pixel_t'($urandom));
      drive_cycle(1'b1, 1'b0, 1'b0, 8'h00);
      for (int c = 0; c < 400; c++) begin
        logic da, v;
        da = (f == 0) ? (c >= 3 && c <= 5) : ($urandom_range(0, 3) == 0);
        v  = ((f == 0) ? 1'b1 : ($urandom_range(0, 3) != 0)) && (q.size() > 0);
        drive_cycle(1'b0, da, v, (q.size() > 0) ? q[0] : 8'h00);
        if (ready_exp && v) void'(q.pop_front());
        checks++;
        if (mon !== exp_mon) begin fails++; $display("[TB] FAIL stall_model f%0d cyc%0d: got %h, want %h", f, c, mon, exp_mon); end
        checks++;
        if (ready_seen !== ready_exp) begin fails++; $display("[TB] FAIL stall_ready f%0d cyc%0d: got %b, want %b", f, c, ready_seen, ready_exp); end
        if (o_done[0] === 1'b1) done_cnt++;
        if (m_done) break;
      end
      // start during the DONE cycle must be ignored
      drive_cycle(1'b1, 1'b0, 1'b0, 8'h00);
      checks++;
      if (mon !== exp_mon) begin fails++; $display("[TB] FAIL stall_done_start f%0d: got %h, want %h", f, mon, exp_mon); end
    end
    checks++;
    if (done_cnt !== 3) begin fails++; $display("[TB] FAIL stall_frames: got %0d frame_done pulses, want 3", done_cnt); end
  endtask

  task automatic test_valid_toggle();
    int wren_cnt = 0;
    select_and_reset(0);
    drive_cycle(1'b1, 1'b0, 1'b0, 8'h00);
    for (int c = 0; c < 16; c++) begin
      logic v;
      v = (c % 2 == 0);
      drive_cycle(1'b0, 1'b0, v, pixel_t'($urandom));
      checks++;
      if (mon !== exp_mon) begin fails++; $display("[TB] FAIL toggle_model cyc%0d: got %h, want %h", c, mon, exp_mon); end
      checks++;
      if (o_wren[0] !== v || (v && o_addr[0] !== 16'(c / 2))) begin
        fails++;
        $display("[TB] FAIL toggle_write cyc%0d: got wren=%b addr=%h, want wren=%b addr=%h", c, o_wren[0], o_addr[0], v, 16'(c / 2));
      end
      if (o_wren[0] === 1'b1) wren_cnt++;
    end
    checks++;
    if (wren_cnt !== 8) begin fails++; $display("[TB] FAIL toggle_count: got %0d writes, want 8", wren_cnt); end
  endtask

  task automatic test_start_mid_frame();
    select_and_reset(0);
    drive_cycle(1'b1, 1'b0, 1'b0, 8'h00);
    for (int c = 0; c < 3; c++) begin
      drive_cycle(1'b0, 1'b0, 1'b1, pixel_t'($urandom));
      checks++;
      if (mon !== exp_mon) begin fails++; $display("[TB] FAIL mid_model px%0d: got %h, want %h", c, mon, exp_mon); end
    end
    drive_cycle(1'b1, 1'b0, 1'b1, 8'h5A);
    checks++;
    if (mon !== exp_mon) begin fails++; $display("[TB] FAIL mid_start_model: got %h, want %h", mon, exp_mon); end
    checks++;
    if (o_addr[0] !== 16'd3 || o_wren[0] !== 1'b1 || o_data[0] !== 8'h5A || o_busy[0] !== 1'b1) begin
      fails++;
      $display("[TB] FAIL mid_start_ignored: got addr=%h wren=%b data=%h busy=%b, want 0003/1/5a/1",
               o_addr[0], o_wren[0], o_data[0], o_busy[0]);
    end
    drive_cycle(1'b0, 1'b0, 1'b1, pixel_t'($urandom));
    reset = 1'b1;
    drive_cycle(1'b0, 1'b0, 1'b1, 8'h33);
    reset = 1'b0;
    checks++;
    if (mon !== 43'h0) begin fails++; $display("[TB] FAIL mid_reset_outputs: got %h, want 0", mon); end
    checks++;
    if (cur_ready !== 1'b0) begin fails++; $display("[TB] FAIL mid_reset_ready: got %b, want 0", cur_ready); end
    drive_cycle(1'b1, 1'b0, 1'b0, 8'h00);
    drive_cycle(1'b0, 1'b0, 1'b1, 8'hAB);
    checks++;
    if (mon !== exp_mon) begin fails++; $display("[TB] FAIL mid_restart_model: got %h, want %h", mon, exp_mon); end
    checks++;
    if (o_addr[0] !== 16'd0 || o_data[0] !== 8'hAB || o_wren[0] !== 1'b1) begin
      fails++;
      $display("[TB] FAIL mid_restart: got addr=%h data=%h wren=%b, want 0000/ab/1", o_addr[0], o_data[0], o_wren[0]);
    end
  endtask

  task automatic test_row_wrap();
    select_and_reset(1);
    drive_cycle(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) begin
      pixel_t px;
      px = pixel_t'($urandom);
      drive_cycle(1'b0, 1'b0, 1'b1, px);
      checks++;
      if (mon !== exp_mon) begin fails++; $display("[TB] FAIL wrap_model px%0d: got %h, want %h", i, mon, exp_mon); end
      if (i == 3) begin
        checks++;
        if (o_addr[1] !== 16'd3 || o_data[1] !== px) begin
          fails++;
          $display("[TB] FAIL wrap_addr: got addr=%h data=%h, want 0003/%h", o_addr[1], o_data[1], px);
        end
      end
    end
    checks++;
    if (o_done[1] !== 1'b1 || o_addr[1] !== 16'd5) begin
      fails++;
      $display("[TB] FAIL wrap_done: got done=%b addr=%h, want 1/0005", o_done[1], o_addr[1]);
    end
  endtask

  task automatic test_full_frame();
    int          done_cnt = 0;
    logic [15:0] done_addr = '0;
    select_and_reset(2);
    drive_cycle(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 65536; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b1, pixel_t'(i));
      checks++;
      if (mon !== exp_mon) begin fails++; $display("[TB] FAIL full_model px%0d: got %h, want %h", i, mon, exp_mon); end
      if (o_done[2] === 1'b1) begin
        done_cnt++;
        done_addr = o_addr[2];
      end
    end
    drive_cycle(1'b0, 1'b0, 1'b1, 8'h00);
    checks++;
    if (mon !== exp_mon) begin fails++; $display("[TB] FAIL full_after: got %h, want %h", mon, exp_mon); end
    checks++;
    if (done_cnt !== 1 || done_addr !== 16'hFFFF) begin
      fails++;
      $display("[TB] FAIL full_done: got %0d pulses at addr %h, want 1 at ffff", done_cnt, done_addr);
    end
    checks++;
`ifdef FB_WRITER_CKSUM_EN
    if (o_cksum[2] !== 16'h8000) begin fails++; $display("[TB] FAIL full_checksum: got %h, want 8000", o_cksum[2]); end
`else
    if (o_cksum[2] !== 16'h0000) begin fails++; $display("[TB] FAIL full_checksum: got %h, want 0000", o_cksum[2]); end
`endif
  endtask

  initial begin
    $display("[TB] frame_buffer_writer bench starting");
    test_reset();
    test_back_to_back();
    test_draw_stall();
    test_valid_toggle();
    test_start_mid_frame();
    test_row_wrap();
    test_full_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
